// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and types
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter owning the last-grant pointer
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int LG_W = (N > 1) ? $clog2(N) : 1;

    logic [LG_W-1:0] last_q;
    logic [LG_W-1:0] last_d;
    logic [LG_W-1:0] win_idx;
    logic            found;

    // Search starts one past the previous winner so every requester gets a turn within N grants.
    always_comb begin
        int idx;
        gnt     = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = LG_W'(idx);
            end
        end
        last_d = (advance && found) ? win_idx : last_q;
    end

    // Pointer resets to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LG_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with registered output stage and pending mask
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    hold,
    output logic                    regWrite,
    output logic [ADDR_W-1:0]       writeReg,
    output logic [DATA_W-1:0]       writeData,
    output logic [2:0]              grant_id,
    output logic [2**ADDR_W-1:0]    pending_mask
);

    logic [N_REQ-1:0]  gnt;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        sel_id;

    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        gid_q, gid_d;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (!hold),
        .gnt     (gnt)
    );

    // Ready is the raw grant, suppressed by hold and while reset is asserted.
    assign req_ready = (hold || !rst_n) ? '0 : gnt;
    assign xfer      = |req_ready;

    // Mux the single accepted requester onto the output-stage inputs.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_id   = 3'(i);
            end
        end
    end

    // Output stage next state: address/data/id hold when idle, write enable is a one-cycle pulse; register 0 never pulses.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (xfer) begin
            wen_d   = (sel_addr != '0);
            waddr_d = sel_addr;
            wdata_d = sel_data;
            gid_d   = sel_id;
        end
    end

    // Output stage registers; async reset drops any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign regWrite  = wen_q;
    assign writeReg  = waddr_q;
    assign writeData = wdata_q;
    assign grant_id  = gid_q;

    // Registers with a write requested or sitting in the output stage; register 0 is never hazardous.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                pending_mask[req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (wen_q) begin
            pending_mask[waddr_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - table-driven self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        hold;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [2:0]  grant_id;
    logic [31:0] pending_mask;

    int n_checks;
    int n_pass;

    rf_wb_arbiter #(
        .N_REQ  (3),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .hold         (hold),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .grant_id     (grant_id),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] base;
        logic        hold;
        logic [2:0]  e_ready;
        logic [31:0] e_pmask;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [2:0]  e_gid;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [31:0] base, input logic hold_v,
                                input logic [2:0] e_ready, input logic [31:0] e_pmask, input logic e_rw,
                                input logic [4:0] e_wreg, input logic [31:0] e_wdata, input logic [2:0] e_gid);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.base = base; v.hold = hold_v;
        v.e_ready = e_ready; v.e_pmask = e_pmask; v.e_rw = e_rw;
        v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_gid = e_gid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] base, input logic hold_v);
        req_valid = valid;
        req_addr  = {a2, a1, a0};
        req_data  = {base + 32'd2, base + 32'd1, base};
        hold      = hold_v;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        //            valid   a0     a1     a2     base           hold  ready   pmask         rw    wreg   wdata          gid
        vecs[0]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,         1'b0, 3'b000, 32'h0,        1'b0, 5'd0,  32'h0,         3'd0);
        vecs[1]  = mk(3'b010, 5'd0,  5'd5,  5'd0,  32'hDEADBEEE,  1'b0, 3'b010, 32'h20,       1'b1, 5'd5,  32'hDEADBEEF,  3'd1);
        vecs[2]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,         1'b0, 3'b000, 32'h20,       1'b0, 5'd5,  32'hDEADBEEF,  3'd1);
        vecs[3]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,         1'b0, 3'b000, 32'h0,        1'b0, 5'd5,  32'hDEADBEEF,  3'd1);
        vecs[4]  = mk(3'b111, 5'd1,  5'd2,  5'd3,  32'h100,       1'b0, 3'b100, 32'hE,        1'b1, 5'd3,  32'h102,       3'd2);
        vecs[5]  = mk(3'b111, 5'd1,  5'd2,  5'd3,  32'h100,       1'b0, 3'b001, 32'hE,        1'b1, 5'd1,  32'h100,       3'd0);
        vecs[6]  = mk(3'b111, 5'd1,  5'd2,  5'd3,  32'h100,       1'b0, 3'b010, 32'hE,        1'b1, 5'd2,  32'h101,       3'd1);
        vecs[7]  = mk(3'b111, 5'd1,  5'd2,  5'd3,  32'h100,       1'b0, 3'b100, 32'hE,        1'b1, 5'd3,  32'h102,       3'd2);
        vecs[8]  = mk(3'b100, 5'd0,  5'd0,  5'd0,  32'h1232,      1'b0, 3'b100, 32'h8,        1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[9]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0,         1'b0, 3'b000, 32'h0,        1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[10] = mk(3'b001, 5'd7,  5'd0,  5'd0,  32'h700,       1'b1, 3'b000, 32'h80,       1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[11] = mk(3'b001, 5'd7,  5'd0,  5'd0,  32'h700,       1'b1, 3'b000, 32'h80,       1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[12] = mk(3'b001, 5'd7,  5'd0,  5'd0,  32'h700,       1'b1, 3'b000, 32'h80,       1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[13] = mk(3'b001, 5'd7,  5'd0,  5'd0,  32'h700,       1'b1, 3'b000, 32'h80,       1'b0, 5'd0,  32'h1234,      3'd2);
        vecs[14] = mk(3'b001, 5'd7,  5'd0,  5'd0,  32'h700,       1'b0, 3'b001, 32'h80,       1'b1, 5'd7,  32'h700,       3'd0);
        vecs[15] = mk(3'b011, 5'd8,  5'd9,  5'd0,  32'h900,       1'b0, 3'b010, 32'h380,      1'b1, 5'd9,  32'h901,       3'd1);
        vecs[16] = mk(3'b101, 5'd9,  5'd0,  5'd9,  32'hA00,       1'b0, 3'b100, 32'h200,      1'b1, 5'd9,  32'hA02,       3'd2);
        vecs[17] = mk(3'b001, 5'd9,  5'd0,  5'd0,  32'hA00,       1'b0, 3'b001, 32'h200,      1'b1, 5'd9,  32'hA00,       3'd0);

        rst_n = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        #7;
        chk("ready_in_reset", 64'(req_ready), 64'h0);
        chk("rw_in_reset", 64'(regWrite), 64'h0);
        chk("gid_in_reset", 64'(grant_id), 64'h0);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            drive(vecs[v].valid, vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].base, vecs[v].hold);
            #1;
            chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].e_ready));
            chk($sformatf("v%0d_pmask", v), 64'(pending_mask), 64'(vecs[v].e_pmask));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regWrite", v), 64'(regWrite), 64'(vecs[v].e_rw));
            chk($sformatf("v%0d_writeReg", v), 64'(writeReg), 64'(vecs[v].e_wreg));
            chk($sformatf("v%0d_writeData", v), 64'(writeData), 64'(vecs[v].e_wdata));
            chk($sformatf("v%0d_grant_id", v), 64'(grant_id), 64'(vecs[v].e_gid));
        end

        // Async reset mid-burst: pointer sits at 0 so requester 1 wins, making 2 next in order.
        @(negedge clk);
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hB00, 1'b0);
        @(posedge clk);
        #1;
        chk("burst_rw", 64'(regWrite), 64'h1);
        chk("burst_gid", 64'(grant_id), 64'h1);
        chk("burst_wreg", 64'(writeReg), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rw_clear", 64'(regWrite), 64'h0);
        chk("async_ready_zero", 64'(req_ready), 64'h0);
        chk("async_wreg_zero", 64'(writeReg), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'h1);
        chk("post_rst_pmask", 64'(pending_mask), 64'hE);
        @(posedge clk);
        #1;
        chk("post_rst_gid", 64'(grant_id), 64'h0);
        chk("post_rst_wreg", 64'(writeReg), 64'h1);
        chk("post_rst_wdata", 64'(writeData), 64'hB00);
        chk("post_rst_rw", 64'(regWrite), 64'h1);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("final_idle_rw", 64'(regWrite), 64'h0);
        chk("final_idle_pmask", 64'(pending_mask), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
